// File: rtl/x64_cfg_seq_pkg.sv
// ----------------------------------------------------------------------------
// x64_cfg_seq_pkg : shared state encoding and width helper for the cluster
//                   configuration sequencer and chip-level config fan-out.
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package x64_cfg_seq_pkg;

  localparam logic [2:0] CS_IDLE = 3'd0;
  localparam logic [2:0] CS_GRST = 3'd1;
  localparam logic [2:0] CS_LOAD = 3'd2;
  localparam logic [2:0] CS_WAIT = 3'd3;
  localparam logic [2:0] CS_RUN  = 3'd4;
  localparam logic [2:0] CS_ERR  = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = CS_IDLE,
    ST_GRST = CS_GRST,
    ST_LOAD = CS_LOAD,
    ST_WAIT = CS_WAIT,
    ST_RUN  = CS_RUN,
    ST_ERR  = CS_ERR
  } cfg_state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/x64_cfg_seq_mod_ctr.sv
// ----------------------------------------------------------------------------
// mod_ctr : modulo-MOD up counter with synchronous clear and enable.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mod_ctr #(
  parameter int W   = 2,
  parameter int MOD = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o
);

  localparam logic [W-1:0] c_last = W'(MOD - 1);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (clr_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= (q_q == c_last) ? '0 : q_q + 1'b1;
    end
  end

  assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/x64_cfg_seq.sv
// ----------------------------------------------------------------------------
// x64_cfg_seq : holds grst while streaming config words into one x64 cluster,
//               then releases it and runs the context counter.
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module x64_cfg_seq
  import x64_cfg_seq_pkg::*;
#(
  parameter int M         = 4,
  parameter int CFG_W     = 5,
  parameter int MAX_WORDS = 4096,
  parameter int GRST_CYC  = 4,
  parameter int TMO_CYC   = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic                             src_valid_i,
  input  logic [CFG_W-1:0]                 src_data_i,
  output logic                             src_ready_o,
  input  logic                             cfgd_i,
  output logic                             grst_o,
  output logic                             cfg_o,
  output logic [CFG_W-1:0]                 cfg_i_o,
  output logic [$clog2(M)-1:0]             m_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic [$clog2(MAX_WORDS+1)-1:0]   wcnt_o
);

  localparam int c_mw = $clog2(M);
  localparam int c_ww = $clog2(MAX_WORDS + 1);
  localparam int c_gw = cnt_w(GRST_CYC);
  localparam int c_tw = cnt_w(TMO_CYC);

  localparam logic [c_ww-1:0] c_max_words = c_ww'(MAX_WORDS);
  localparam logic [c_gw-1:0] c_g_last    = c_gw'(GRST_CYC - 1);
  localparam logic [c_tw-1:0] c_t_last    = c_tw'(TMO_CYC - 1);

  cfg_state_e        state_q, state_d;
  logic [c_gw-1:0]   gcnt_q, gcnt_d;
  logic [c_tw-1:0]   tcnt_q, tcnt_d;
  logic [c_ww-1:0]   wcnt_q, wcnt_d;
  logic              cfg_q, grst_q, busy_q, done_q, err_q;
  logic [CFG_W-1:0]  cfg_data_q;
  logic              xfer;
  logic              m_clr;

  always_comb begin
    state_d     = state_q;
    gcnt_d      = gcnt_q;
    tcnt_d      = tcnt_q;
    wcnt_d      = wcnt_q;
    // cfgd gates ready so a word offered alongside cfgd stays with the source.
    src_ready_o = (state_q == ST_LOAD) && (wcnt_q < c_max_words) && !cfgd_i;
    xfer        = src_valid_i && src_ready_o;

    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (start_i) begin
          state_d = ST_GRST;
          gcnt_d  = '0;
          wcnt_d  = '0;
        end
      end
      ST_GRST: begin
        gcnt_d = gcnt_q + 1'b1;
        if (gcnt_q == c_g_last) begin
          state_d = ST_LOAD;
          wcnt_d  = '0;
        end
      end
      ST_LOAD: begin
        if (xfer) wcnt_d = wcnt_q + 1'b1;
        if (cfgd_i) begin
          state_d = ST_RUN;
        end else if (wcnt_q == c_max_words) begin
          state_d = ST_WAIT;
          tcnt_d  = '0;
        end
      end
      ST_WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (cfgd_i) begin
          state_d = ST_RUN;
        end else if (tcnt_q == c_t_last) begin
          state_d = ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      gcnt_q     <= '0;
      tcnt_q     <= '0;
      wcnt_q     <= '0;
      cfg_q      <= 1'b0;
      cfg_data_q <= '0;
      grst_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      tcnt_q  <= tcnt_d;
      wcnt_q  <= wcnt_d;
      cfg_q   <= xfer;
      if (xfer) cfg_data_q <= src_data_i;
      grst_q  <= (state_d != ST_RUN);
      busy_q  <= (state_d inside {ST_GRST, ST_LOAD, ST_WAIT});
      done_q  <= (state_d == ST_RUN);
      err_q   <= (state_d == ST_ERR);
    end
  end

  // m restarts at 0 on the first RUN cycle and only advances while RUN persists.
  assign m_clr = !((state_q == ST_RUN) && (state_d == ST_RUN));

  mod_ctr #(
    .W   (c_mw),
    .MOD (M)
  ) u_m_ctr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (m_clr),
    .en_i   (1'b1),
    .q_o    (m_o)
  );

  assign grst_o  = grst_q;
  assign cfg_o   = cfg_q;
  assign cfg_i_o = cfg_data_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign wcnt_o  = wcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_x64_cfg_seq.sv
// ----------------------------------------------------------------------------
// tb_x64_cfg_seq : directed bench for x64_cfg_seq with a config-word scoreboard.
// Revision       : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_x64_cfg_seq;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n, start, src_valid, cfgd;
  logic [4:0]  src_data;
  logic        src_ready, grst, cfg, busy, done, err;
  logic [4:0]  cfg_dat;
  logic [1:0]  m;
  logic [12:0] wcnt;

  logic        rst8, start8, valid8, cfgd8;
  logic [4:0]  data8;
  logic        ready8, grst8, cfg8, busy8, done8, err8;
  logic [4:0]  cfg_dat8;
  logic [1:0]  m8;
  logic [3:0]  wcnt8;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [4:0] sb[$];

  x64_cfg_seq #(
    .M(4), .CFG_W(5), .MAX_WORDS(4096), .GRST_CYC(4), .TMO_CYC(TMO)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .src_valid_i(src_valid),
    .src_data_i(src_data), .src_ready_o(src_ready), .cfgd_i(cfgd),
    .grst_o(grst), .cfg_o(cfg), .cfg_i_o(cfg_dat), .m_o(m), .busy_o(busy),
    .done_o(done), .err_o(err), .wcnt_o(wcnt)
  );

  x64_cfg_seq #(
    .M(4), .CFG_W(5), .MAX_WORDS(8), .GRST_CYC(4), .TMO_CYC(TMO)
  ) u_dut8 (
    .clk_i(clk), .rst_ni(rst8), .start_i(start8), .src_valid_i(valid8),
    .src_data_i(data8), .src_ready_o(ready8), .cfgd_i(cfgd8),
    .grst_o(grst8), .cfg_o(cfg8), .cfg_i_o(cfg_dat8), .m_o(m8), .busy_o(busy8),
    .done_o(done8), .err_o(err8), .wcnt_o(wcnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record any handshake into the scoreboard, then check the macro side.
  task automatic step(output bit x);
    logic [4:0] e;
    #1;
    x = rst_n & src_valid & src_ready;
    if (x) sb.push_back(src_data);
    @(posedge clk);
    #1;
    cyc++;
    chk("cfg", cfg, x);
    if (x) begin
      e = sb.pop_front();
      chk("cfg_i", cfg_dat, e);
    end
  endtask

  task automatic send(input logic [4:0] d);
    bit x = 1'b0;
    src_valid = 1'b1;
    src_data  = d;
    for (int i = 0; i < 40 && !x; i++) step(x);
    chk("send", x, 1);
  endtask

  task automatic wait_ready();
    bit x;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (src_ready) break;
      step(x);
    end
    chk("ready", src_ready, 1);
  endtask

  task automatic step8();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [4:0] d);
    bit got = 1'b0;
    valid8 = 1'b1;
    data8  = d;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      got = ready8;
      step8();
    end
    chk("t3_send", got, 1);
    chk("t3_cfg", cfg8, 1);
    chk("t3_cfg_i", cfg_dat8, d);
  endtask

  initial begin
    bit x;
    int c_first;
    int n;
    rst_n = 1'b0; start = 1'b0; src_valid = 1'b0; src_data = '0; cfgd = 1'b0;
    rst8  = 1'b0; start8 = 1'b0; valid8 = 1'b0; data8 = '0; cfgd8 = 1'b0;

    // Reset values
    step(x); step(x);
    chk("rst_grst", grst, 1);
    chk("rst_cfg_i", cfg_dat, 0);
    chk("rst_m", m, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wcnt", wcnt, 0);
    chk("rst_ready", src_ready, 0);

    // 1: ten back-to-back words, then cfgd
    rst_n = 1'b1;
    start = 1'b1; step(x); start = 1'b0;
    chk("t1_busy", busy, 1);
    send(5'h01);
    c_first = cyc;
    for (int k = 2; k <= 10; k++) send(5'(k));
    chk("t1_burst_cycles", cyc - c_first, 9);
    src_valid = 1'b0;
    chk("t1_wcnt", wcnt, 10);
    chk("t1_grst_load", grst, 1);
    cfgd = 1'b1; step(x); cfgd = 1'b0;
    chk("t1_grst_run", grst, 0);
    chk("t1_done", done, 1);
    chk("t1_busy_run", busy, 0);
    chk("t1_m0", m, 0);
    for (int k = 1; k <= 4; k++) begin
      step(x);
      chk("t1_m", m, k % 4);
    end

    // 6a: start in RUN restarts the load
    start = 1'b1; step(x); start = 1'b0;
    chk("t6_done", done, 0);
    chk("t6_grst", grst, 1);
    chk("t6_busy", busy, 1);
    chk("t6_wcnt", wcnt, 0);
    // 6b: start during GRST ignored
    start = 1'b1; step(x); start = 1'b0;
    chk("t6_grst_busy", busy, 1);
    wait_ready();

    // 2: valid toggling 1,0,1,0
    for (int k = 0; k < 4; k++) begin
      src_valid = 1'b1; src_data = 5'(8'h11 + k);
      step(x);
      chk("t2_xfer", x, 1);
      src_valid = 1'b0;
      step(x);
    end
    chk("t2_wcnt", wcnt, 4);
    // 6c: start during LOAD ignored
    start = 1'b1; step(x); start = 1'b0;
    chk("t6_load_wcnt", wcnt, 4);
    chk("t6_load_busy", busy, 1);

    // 4: cfgd with a concurrent valid word
    src_valid = 1'b1; src_data = 5'h1F; cfgd = 1'b1;
    #1;
    chk("t4_ready", src_ready, 0);
    step(x);
    src_valid = 1'b0; cfgd = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_wcnt", wcnt, 4);
    chk("t4_sb_empty", sb.size(), 0);

    // 5: reset mid-load after three words
    start = 1'b1; step(x); start = 1'b0;
    wait_ready();
    send(5'h05); send(5'h06); send(5'h07);
    src_data = 5'h08;
    rst_n = 1'b0; step(x);
    chk("t5_grst", grst, 1);
    chk("t5_cfg_i", cfg_dat, 0);
    chk("t5_m", m, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_err", err, 0);
    chk("t5_wcnt", wcnt, 0);
    chk("t5_ready", src_ready, 0);
    rst_n = 1'b1; src_valid = 1'b0; step(x);
    start = 1'b1; step(x); start = 1'b0;
    wait_ready();
    send(5'h0A); send(5'h0B);
    src_valid = 1'b0;
    chk("t5_reload_wcnt", wcnt, 2);
    cfgd = 1'b1; step(x); cfgd = 1'b0;
    chk("t5_done", done, 1);

    // 3: MAX_WORDS=8 instance, cfgd never arrives
    rst8 = 1'b1;
    step8();
    start8 = 1'b1; step8(); start8 = 1'b0;
    for (int k = 1; k <= 8; k++) send8(5'(k));
    data8 = 5'h09;
    #1;
    chk("t3_ready_full", ready8, 0);
    chk("t3_wcnt_full", wcnt8, 8);
    n = 0;
    while (!err8 && n < 40) begin
      step8();
      n++;
    end
    // one LOAD cycle sees the full count, then TMO cycles in WAIT
    chk("t3_tmo_cycles", n, TMO + 1);
    chk("t3_err", err8, 1);
    chk("t3_grst", grst8, 1);
    chk("t3_wcnt_sat", wcnt8, 8);
    chk("t3_busy", busy8, 0);
    valid8 = 1'b0;
    start8 = 1'b1; step8(); start8 = 1'b0;
    chk("t3_restart_busy", busy8, 1);
    chk("t3_restart_err", err8, 0);
    chk("t3_restart_wcnt", wcnt8, 0);
    chk("t3_restart_grst", grst8, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
